// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the unified memory-port arbiter.
//   arb_state_t  : arbiter FSM states
//   TIMEOUT_DATA : read data returned when an access is abandoned on timeout
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_select.sv
// arb_select
// Grant decision between fetch and data requesters plus the saturating
// data-streak counter that bounds how long fetch can be starved.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   ireq, dreq   : fetch / data requests
//   grant_en     : arbiter is in IDLE and will act on the grant this cycle
//   grant_d      : data wins arbitration
//   grant_i      : fetch wins arbitration
module arb_select
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ireq,
  input  logic dreq,
  input  logic grant_en,
  output logic grant_d,
  output logic grant_i
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;

  // Data wins unless fetch is waiting and data has already had its streak.
  // The streak only counts data grants that actually delayed a fetch, so a
  // data grant with no fetch pending restarts the count.
  always_comb begin
    grant_d  = dreq & (~ireq | (streak_q < STREAK_MAX));
    grant_i  = ireq & ~grant_d;
    streak_d = streak_q;
    if (grant_en) begin
      if (grant_d) begin
        if (ireq) begin
          if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else begin
          streak_d = '0;
        end
      end else if (grant_i) begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one variable-latency memory port between the fetch stage and the
// memory stage. Each access runs IDLE -> BUSY_x -> DONE_x; the requester is
// stalled until its one-cycle ready pulse.
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   ireq/iaddr/irdata/iready       : fetch side
//   dreq/dwe/daddr/dwdata/drdata/dready : data side
//   stall                          : combined pipeline stall
//   mreq/mwe/maddr/mwdata          : memory request (held until mack)
//   mrdata/mack                    : memory response
//   bus_err                        : timeout indication, coincident with ready
// Optional feature: define MEM_ARB_TIMEOUT_EN to abandon accesses that see
// no mack within TIMEOUT_CYCLES BUSY cycles. Without it BUSY waits forever
// and bus_err is constant 0.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          iready,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dready,
  output logic          stall,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  input  logic          mack,
  output logic          bus_err
);

  arb_state_t    state_q, state_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic          mwe_q, mwe_d;
  logic [DW-1:0] mwdata_q, mwdata_d;
  logic [DW-1:0] irdata_q, irdata_d;
  logic [DW-1:0] drdata_q, drdata_d;

  logic grant_en;
  logic grant_d;
  logic grant_i;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] TIMEOUT_WORD = DW'(TIMEOUT_DATA);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          bus_err_q, bus_err_d;
`endif

  assign grant_en = (state_q == IDLE);

  arb_select #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_select (
    .clk     (clk),
    .reset   (reset),
    .ireq    (ireq),
    .dreq    (dreq),
    .grant_en(grant_en),
    .grant_d (grant_d),
    .grant_i (grant_i)
  );

  // Next-state and datapath latches. Requests are only looked at in IDLE;
  // during BUSY the latched address/data drive the memory, so requester
  // inputs may change freely. mack is only honoured in BUSY.
  always_comb begin
    state_d  = state_q;
    maddr_d  = maddr_q;
    mwe_d    = mwe_q;
    mwdata_d = mwdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    bus_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        if (grant_d) begin
          maddr_d  = daddr;
          mwe_d    = dwe;
          mwdata_d = dwdata;
          state_d  = BUSY_D;
        end else if (grant_i) begin
          maddr_d = iaddr;
          mwe_d   = 1'b0;
          state_d = BUSY_I;
        end
      end
      BUSY_I: begin
        if (mack) begin
          irdata_d = mrdata;
          state_d  = DONE_I;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TIMEOUT_LAST) begin
          irdata_d  = TIMEOUT_WORD;
          bus_err_d = 1'b1;
          state_d   = DONE_I;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      BUSY_D: begin
        // A write leaves drdata untouched so the last read value survives.
        if (mack) begin
          if (!mwe_q) begin
            drdata_d = mrdata;
          end
          state_d = DONE_D;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TIMEOUT_LAST) begin
          if (!mwe_q) begin
            drdata_d = TIMEOUT_WORD;
          end
          bus_err_d = 1'b1;
          state_d   = DONE_D;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      DONE_I, DONE_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      maddr_q  <= '0;
      mwe_q    <= 1'b0;
      mwdata_q <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      maddr_q  <= maddr_d;
      mwe_q    <= mwe_d;
      mwdata_q <= mwdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Ready pulses and mreq are decoded from state, so a mid-access reset
  // drops them immediately.
  assign mreq   = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign iready = (state_q == DONE_I);
  assign dready = (state_q == DONE_D);
  assign mwe    = mwe_q;
  assign maddr  = maddr_q;
  assign mwdata = mwdata_q;
  assign irdata = irdata_q;
  assign drdata = drdata_q;
  assign stall  = (ireq & ~iready) | (dreq & ~dready);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run against a transaction-level model of the arbitration rule
// and a behavioural memory. Define MEM_ARB_TIMEOUT_EN to exercise the
// timeout path.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int MAX = 4;
  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic        ireq, dreq, dwe, mack;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic [31:0] irdata, drdata, maddr, mwdata;
  logic        iready, dready, stall, mreq, mwe, bus_err;

  int checks = 0;
  int errors = 0;

  // Behavioural memory: unwritten words return a hash of the address.
  logic [31:0] mem [logic [31:0]];
  bit mem_off  = 0;
  bit mem_rand = 0;
  int mem_lat  = 0;
  int wait_cnt = 0;
  bit busy     = 0;

  mem_arbiter #(
    .AW(32), .DW(32), .MAX_DATA_STREAK(MAX), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata), .dready(dready), .stall(stall),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
    .mrdata(mrdata), .mack(mack), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  // Memory responder: acks after mem_lat (or random 0..3) extra BUSY cycles.
  initial begin
    mack   = 1'b0;
    mrdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_off) begin
        busy = 0;
      end else if (mreq !== 1'b1) begin
        mack = 1'b0;
        busy = 0;
      end else if (mack) begin
        mack = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1;
          wait_cnt = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
        end
        if (wait_cnt == 0) begin
          mack = 1'b1;
          if (mwe) begin
            mem[maddr] = mwdata;
            mrdata = $urandom();
          end else begin
            mrdata = mem_rd(maddr);
          end
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ireq = 0; dreq = 0; dwe = 0;
    iaddr = '0; daddr = '0; dwdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({mreq, mwe, iready, dready, bus_err, stall} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got %b exp 000000",
               {mreq, mwe, iready, dready, bus_err, stall});
    end
    checks++;
    if ({maddr, mwdata, irdata, drdata} !== 128'b0) begin
      errors++;
      $display("[TB] FAIL reset_data got %h %h %h %h exp all zero", maddr, mwdata, irdata, drdata);
    end
    step();
    step();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({mreq, iready, dready, bus_err} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle got %b exp 0000", {mreq, iready, dready, bus_err});
    end
  endtask

  task automatic test_fetch_zero_wait();
    mem[32'h40] = 32'h2008_0005;
    mem_off = 0; mem_rand = 0; mem_lat = 0;
    ireq = 1; iaddr = 32'h40;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fetch_stall_c1 got %b exp 1", stall);
    end
    step();
    checks++;
    if ({mreq, mwe, iready, stall} !== 4'b1001 || maddr !== 32'h40) begin
      errors++;
      $display("[TB] FAIL fetch_busy got %b maddr %h exp 1001 maddr 40",
               {mreq, mwe, iready, stall}, maddr);
    end
    step();
    checks++;
    if ({mreq, iready, dready, stall} !== 4'b0100 || irdata !== 32'h2008_0005) begin
      errors++;
      $display("[TB] FAIL fetch_done got %b irdata %h exp 0100 irdata 20080005",
               {mreq, iready, dready, stall}, irdata);
    end
    ireq = 0;
    step();
    checks++;
    if ({mreq, iready} !== 2'b00 || irdata !== 32'h2008_0005) begin
      errors++;
      $display("[TB] FAIL fetch_hold got %b irdata %h exp 00 irdata 20080005",
               {mreq, iready}, irdata);
    end
  endtask

  task automatic test_write_delay();
    int n;
    mem_lat = 3;
    dreq = 1; dwe = 1; daddr = 32'h54; dwdata = 32'h7;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mreq, mwe, dready} !== 3'b110 || maddr !== 32'h54 || mwdata !== 32'h7) begin
        errors++;
        $display("[TB] FAIL write_busy%0d got %b maddr %h mwdata %h exp 110 54 7",
                 k, {mreq, mwe, dready}, maddr, mwdata);
      end
      if (k == 0) begin
        daddr = 32'h99; dwdata = 32'h1234;
      end
      step();
    end
    checks++;
    if ({mreq, dready} !== 2'b01 || drdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL write_done got %b drdata %h exp 01 drdata 0", {mreq, dready}, drdata);
    end
    dreq = 0; dwe = 0; daddr = 32'h54; dwdata = '0;
    step();
    mem_lat = 0;
    dreq = 1;
    n = 0;
    do begin step(); n++; end while (dready !== 1'b1 && n < 20);
    checks++;
    if (dready !== 1'b1 || drdata !== 32'h7) begin
      errors++;
      $display("[TB] FAIL write_readback got dready %b drdata %h exp 1 7", dready, drdata);
    end
    dreq = 0;
    step();
  endtask

  task automatic test_contention();
    int  n;
    bit  is_i, exp_i;
    do_reset();
    mem_lat = 1;
    ireq = 1; iaddr = 32'h100;
    dreq = 1; dwe = 0; daddr = 32'h8000_0200;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      do begin step(); n++; end while (mreq !== 1'b1 && n < 20);
      is_i  = (maddr === iaddr);
      exp_i = ((k % (MAX + 1)) == MAX);
      checks++;
      if (mreq !== 1'b1 || is_i != exp_i) begin
        errors++;
        $display("[TB] FAIL contention_grant%0d got %s exp %s", k,
                 (mreq !== 1'b1) ? "none" : (is_i ? "I" : "D"), exp_i ? "I" : "D");
      end
      n = 0;
      do begin step(); n++; end while (mreq === 1'b1 && n < 20);
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    mem_off = 1; mack = 0;
    dreq = 1; dwe = 0; daddr = 32'h8000_0010;
    n = 0;
    do begin step(); n++; end while (mreq !== 1'b1 && n < 10);
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({mreq, dready, iready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midreset_abort got %b exp 000", {mreq, dready, iready});
    end
    mem_off = 0; mem_lat = 0;
    step();
    checks++;
    if (dready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_noready got %b exp 0", dready);
    end
    reset = 1'b1;
    step();
    checks++;
    if (mreq !== 1'b1 || maddr !== 32'h8000_0010) begin
      errors++;
      $display("[TB] FAIL midreset_regrant got mreq %b maddr %h exp 1 80000010", mreq, maddr);
    end
    n = 0;
    do begin step(); n++; end while (dready !== 1'b1 && n < 20);
    checks++;
    if (dready !== 1'b1 || drdata !== mem_rd(32'h8000_0010)) begin
      errors++;
      $display("[TB] FAIL midreset_data got dready %b drdata %h exp 1 %h",
               dready, drdata, mem_rd(32'h8000_0010));
    end
    dreq = 0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    int busy_n;
    mem_off = 1; mack = 0;
    dreq = 1; dwe = 0; daddr = 32'h8000_0020;
    n = 0;
    do begin step(); n++; end while (mreq !== 1'b1 && n < 10);
`ifdef MEM_ARB_TIMEOUT_EN
    busy_n = 0;
    n = 0;
    while (mreq === 1'b1 && n < 40) begin
      busy_n++;
      step();
      n++;
    end
    checks++;
    if (busy_n != TMO) begin
      errors++;
      $display("[TB] FAIL timeout_len got %0d busy cycles exp %0d", busy_n, TMO);
    end
    checks++;
    if ({dready, bus_err} !== 2'b11 || drdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL timeout_done got %b drdata %h exp 11 deadbeef", {dready, bus_err}, drdata);
    end
    dreq = 0;
    mack = 1'b1;
    step();
    mack = 1'b0;
    checks++;
    if ({mreq, dready, bus_err} !== 3'b000 || drdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL timeout_late_ack got %b drdata %h exp 000 deadbeef",
               {mreq, dready, bus_err}, drdata);
    end
    step();
    checks++;
    if ({mreq, dready, bus_err} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL timeout_after got %b exp 000", {mreq, dready, bus_err});
    end
    mem_off = 0;
`else
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (mreq === 1'b1 && bus_err === 1'b0 && dready === 1'b0) busy_n++;
    end
    checks++;
    if (busy_n != 40) begin
      errors++;
      $display("[TB] FAIL notimeout_wait got %0d busy cycles exp 40", busy_n);
    end
    mem_off = 0; mem_lat = 0;
    n = 0;
    do begin step(); n++; end while (dready !== 1'b1 && n < 10);
    checks++;
    if (dready !== 1'b1 || bus_err !== 1'b0 || drdata !== mem_rd(32'h8000_0020)) begin
      errors++;
      $display("[TB] FAIL notimeout_done got dready %b bus_err %b drdata %h exp 1 0 %h",
               dready, bus_err, drdata, mem_rd(32'h8000_0020));
    end
    dreq = 0;
    step();
`endif
  endtask

  task automatic test_random();
    int          m_streak;
    int          own;
    int          wd;
    int          done_n;
    bit          prev_mreq;
    bit          exp_d, exp_i, ok;
    logic [31:0] last_dr;
    localparam int NCYC = 2000;
    do_reset();
    mem_rand = 1; mem_off = 0;
    m_streak = 0; own = 0; wd = 0; done_n = 0;
    prev_mreq = 0; last_dr = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      step();
      if (mreq === 1'b1 && !prev_mreq) begin
        exp_d = dreq && (!ireq || m_streak < MAX);
        exp_i = !exp_d && ireq;
        checks++;
        if (!(exp_d || exp_i) || maddr !== (exp_d ? daddr : iaddr) ||
            mwe !== (exp_d ? dwe : 1'b0)) begin
          errors++;
          $display("[TB] FAIL rand_grant cyc %0d got maddr %h mwe %b exp %s maddr %h",
                   cyc, maddr, mwe, exp_d ? "D" : (exp_i ? "I" : "none"), exp_d ? daddr : iaddr);
        end
        if (exp_d) m_streak = ireq ? ((m_streak < MAX) ? m_streak + 1 : MAX) : 0;
        else m_streak = 0;
        own = exp_d ? 2 : (exp_i ? 1 : 0);
      end
      prev_mreq = (mreq === 1'b1);
      checks++;
      if (stall !== ((ireq & ~iready) | (dreq & ~dready))) begin
        errors++;
        $display("[TB] FAIL rand_stall cyc %0d got %b", cyc, stall);
      end
      if (iready === 1'b1 || dready === 1'b1) begin
        ok = 1;
        if (iready === 1'b1 && dready === 1'b1) ok = 0;
        else if (iready === 1'b1) ok = (own == 1) && (irdata === mem_rd(iaddr));
        else if (dwe) ok = (own == 2) && (drdata === last_dr);
        else ok = (own == 2) && (drdata === mem_rd(daddr));
        checks++;
        if (!ok) begin
          errors++;
          $display("[TB] FAIL rand_ready cyc %0d got i%b d%b ir %h dr %h owner %0d", cyc,
                   iready, dready, irdata, drdata, own);
        end
        if (dready === 1'b1 && !dwe) last_dr = mem_rd(daddr);
        own = 0;
        wd = 0;
        done_n++;
      end else if (ireq || dreq) begin
        wd++;
      end
      if (wd > 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL rand_watchdog cyc %0d no ready for %0d cycles", cyc, wd);
        break;
      end
      if (iready === 1'b1) begin
        if (cyc > NCYC - 100 || $urandom_range(0, 1) == 0) ireq = 0;
        else iaddr = $urandom_range(0, 63) << 2;
      end else if (!ireq && cyc < NCYC - 100 && $urandom_range(0, 3) == 0) begin
        ireq = 1;
        iaddr = $urandom_range(0, 63) << 2;
      end
      if (dready === 1'b1) begin
        if (cyc > NCYC - 100 || $urandom_range(0, 1) == 0) begin
          dreq = 0;
        end else begin
          daddr = 32'h8000_0000 | ($urandom_range(0, 15) << 2);
          dwe = $urandom_range(0, 1);
          dwdata = $urandom();
        end
      end else if (!dreq && cyc < NCYC - 100 && $urandom_range(0, 2) == 0) begin
        dreq = 1;
        daddr = 32'h8000_0000 | ($urandom_range(0, 15) << 2);
        dwe = $urandom_range(0, 1);
        dwdata = $urandom();
      end
    end
    checks++;
    if (ireq || dreq || mreq !== 1'b0 || done_n < 100) begin
      errors++;
      $display("[TB] FAIL rand_drain got ireq %b dreq %b mreq %b done %0d", ireq, dreq, mreq, done_n);
    end
    mem_rand = 0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch_zero_wait();
    test_write_delay();
    test_contention();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
